// File: rtl/pika_pkg.sv
// Shared definitions for the pika game blocks: state and side encodings, default
// playfield geometry and small score helpers.
package pika_pkg;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_WAIT  = 2'd1,
        ST_PLAY  = 2'd2,
        ST_END   = 2'd3
    } game_state_e;

    localparam logic SIDE_PLAYER = 1'b0;
    localparam logic SIDE_NPC    = 1'b1;

    localparam int BALL_W   = 30;
    localparam int BALL_H   = 30;
    localparam int NET_X    = 160;
    localparam int NET_W    = 6;
    localparam int GROUND_Y = 220;

    localparam logic [3:0] SCORE_MAX = 4'd15;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == SCORE_MAX) ? v : v + 4'd1;
    endfunction

    // True when the winner is at least two points ahead.
    function automatic logic leads_by_two(input logic [3:0] win_s, input logic [3:0] lose_s);
        return ({1'b0, win_s} >= ({1'b0, lose_s} + 5'd2));
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector with a registered history bit; the history resets high so a
// level already asserted when reset releases does not produce an edge.
module rise_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/game_referee.sv
// Match referee: detects ball landings, awards points, sequences the serve delay and
// ends the match. Build option PIKA_WIN_BY_TWO_EN requires a two-point lead to win.
module game_referee
    import pika_pkg::game_state_e, pika_pkg::ST_START, pika_pkg::ST_WAIT,
           pika_pkg::ST_PLAY, pika_pkg::ST_END, pika_pkg::SIDE_PLAYER,
           pika_pkg::SIDE_NPC, pika_pkg::SCORE_MAX, pika_pkg::sat_inc,
           pika_pkg::leads_by_two;
#(
    parameter int BALL_H      = pika_pkg::BALL_H,
    parameter int BALL_W      = pika_pkg::BALL_W,
    parameter int GROUND_Y    = pika_pkg::GROUND_Y,
    parameter int NET_X       = pika_pkg::NET_X,
    parameter int NET_W       = pika_pkg::NET_W,
    parameter int WIN_SCORE   = 5,
    parameter int SERVE_DELAY = 50000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_start,
    input  logic [11:0] Ball_X,
    input  logic [11:0] Ball_Y,
    output logic [1:0]  game_state,
    output logic        who_win,
    output logic [3:0]  score_player,
    output logic [3:0]  score_npc,
    output logic        point_pulse
);

    localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);
    localparam logic [3:0] WIN_S = 4'(WIN_SCORE);

    game_state_e      state_q;
    logic             who_q;
    logic [3:0]       score_player_q;
    logic [3:0]       score_npc_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q;

    logic       start_rise;
    logic       land;
    logic       left_side;
    logic       point_side;
    logic [3:0] win_new;
    logic [3:0] lose_cur;
    logic       match_over;

    rise_detect #(
        .RESET_VAL (1'b1)
    ) u_start_rise (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_i   (btn_start),
        .rise_o  (start_rise)
    );

    // 13-bit sums so a ball near the 12-bit limit cannot wrap back above the line.
    assign land      = ({1'b0, Ball_Y} + 13'(BALL_H)) >= 13'(GROUND_Y);
    assign left_side = ({1'b0, Ball_X} + 13'(BALL_W / 2)) < 13'(NET_X + NET_W / 2);

    // A ball landing on the NPC (left) half is the player's point.
    assign point_side = left_side ? SIDE_PLAYER : SIDE_NPC;
    assign win_new    = left_side ? sat_inc(score_player_q) : sat_inc(score_npc_q);
    assign lose_cur   = left_side ? score_npc_q : score_player_q;

`ifdef PIKA_WIN_BY_TWO_EN
    assign match_over = (win_new == SCORE_MAX) ||
                        ((win_new >= WIN_S) && leads_by_two(win_new, lose_cur));
`else
    assign match_over = (win_new == WIN_S);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_START;
            who_q          <= SIDE_PLAYER;
            score_player_q <= '0;
            score_npc_q    <= '0;
            pulse_q        <= 1'b0;
            cnt_q          <= '0;
        end else begin
            pulse_q <= 1'b0;
            unique case (state_q)
                ST_START: begin
                    if (start_rise) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_PLAY;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_PLAY: begin
                    // Leaving PLAY on the same edge limits a grounded ball to one point.
                    if (land) begin
                        pulse_q <= 1'b1;
                        who_q   <= point_side;
                        if (left_side) begin
                            score_player_q <= win_new;
                        end else begin
                            score_npc_q <= win_new;
                        end
                        state_q <= match_over ? ST_END : ST_WAIT;
                        cnt_q   <= '0;
                    end
                end
                ST_END: begin
                    // who_q is kept so the previous winner serves the new match.
                    if (start_rise) begin
                        score_player_q <= '0;
                        score_npc_q    <= '0;
                        state_q        <= ST_WAIT;
                        cnt_q          <= '0;
                    end
                end
                default: state_q <= ST_START;
            endcase
        end
    end

    assign game_state   = state_q;
    assign who_win      = who_q;
    assign score_player = score_player_q;
    assign score_npc    = score_npc_q;
    assign point_pulse  = pulse_q;

endmodule

// File: tb/tb_game_referee.sv
// Scoreboard bench for game_referee with SERVE_DELAY=4, WIN_SCORE=3; the win-by-two
// sequence is exercised when PIKA_WIN_BY_TWO_EN is defined.
module tb_game_referee;
    import pika_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        btn_start;
    logic [11:0] Ball_X;
    logic [11:0] Ball_Y;
    logic [1:0]  game_state;
    logic        who_win;
    logic [3:0]  score_player;
    logic [3:0]  score_npc;
    logic        point_pulse;

    game_referee #(
        .WIN_SCORE   (3),
        .SERVE_DELAY (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_start    (btn_start),
        .Ball_X       (Ball_X),
        .Ball_Y       (Ball_Y),
        .game_state   (game_state),
        .who_win      (who_win),
        .score_player (score_player),
        .score_npc    (score_npc),
        .point_pulse  (point_pulse)
    );

    typedef struct {
        logic [1:0] st;
        logic       who;
        logic [3:0] sp;
        logic [3:0] sn;
        logic       pulse;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic [1:0] prev_st = 2'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Monitor: any state change or point strobe is an event that must match the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            prev_st = game_state;
        end else if ((game_state != prev_st) || point_pulse) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event cyc=%0d got st=%0d pulse=%0b sp=%0d sn=%0d who=%0b",
                         cyc, game_state, point_pulse, score_player, score_npc, who_win);
            end else begin
                e = sb.pop_front();
                if (game_state !== e.st || point_pulse !== e.pulse || who_win !== e.who ||
                    score_player !== e.sp || score_npc !== e.sn || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL event cyc=%0d st=%0d pulse=%0b who=%0b sp=%0d sn=%0d | want cyc=%0d st=%0d pulse=%0b who=%0b sp=%0d sn=%0d",
                             cyc, game_state, point_pulse, who_win, score_player, score_npc,
                             e.cyc, e.st, e.pulse, e.who, e.sp, e.sn);
                end
            end
            prev_st = game_state;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [1:0] st, input logic who, input logic [3:0] sp,
                             input logic [3:0] sn, input logic pulse, input int at);
        exp_t e;
        e.st = st; e.who = who; e.sp = sp; e.sn = sn; e.pulse = pulse; e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, int'(game_state), 0);
        chk({tag, "_who"},   int'(who_win), 0);
        chk({tag, "_sp"},    int'(score_player), 0);
        chk({tag, "_sn"},    int'(score_npc), 0);
        chk({tag, "_pulse"}, int'(point_pulse), 0);
    endtask

    // Press start from a released button; WAIT next edge, PLAY four edges later.
    task automatic press(input logic who, input logic [3:0] sp, input logic [3:0] sn);
        btn_start = 1'b0;
        step();
        btn_start = 1'b1;
        expect_ev(ST_WAIT, who, sp, sn, 1'b0, cyc + 1);
        expect_ev(ST_PLAY, who, sp, sn, 1'b0, cyc + 5);
        step();
        btn_start = 1'b0;
        repeat (4) step();
    endtask

    // Land the ball in PLAY and keep it grounded through the serve wait.
    task automatic rally(input logic [11:0] x, input logic [11:0] y, input logic who,
                         input logic [3:0] sp, input logic [3:0] sn, input logic [1:0] st_after);
        Ball_X = x;
        Ball_Y = y;
        expect_ev(st_after, who, sp, sn, 1'b1, cyc + 1);
        if (st_after == ST_WAIT) expect_ev(ST_PLAY, who, sp, sn, 1'b0, cyc + 5);
        repeat (4) step();
        Ball_Y = 12'd0;
        step();
    endtask

    initial begin
        reset_n   = 1'b1;
        btn_start = 1'b1;
        Ball_X    = 12'd0;
        Ball_Y    = 12'd0;
        #1 reset_n = 1'b0;
        #10;
        chk_reset_vals("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) step();

        press(1'b0, 4'd0, 4'd0);
        rally(12'd100, 12'd190, 1'b0, 4'd1, 4'd0, ST_WAIT);
        rally(12'd148, 12'd190, 1'b1, 4'd1, 4'd1, ST_WAIT);
        Ball_X = 12'd148;
        Ball_Y = 12'd189;
        repeat (3) step();
        Ball_Y = 12'd0;
        rally(12'd147, 12'd190, 1'b0, 4'd2, 4'd1, ST_WAIT);
`ifdef PIKA_WIN_BY_TWO_EN
        rally(12'd148, 12'd190, 1'b1, 4'd2, 4'd2, ST_WAIT);
        rally(12'd100, 12'd190, 1'b0, 4'd3, 4'd2, ST_WAIT);
        rally(12'd148, 12'd190, 1'b1, 4'd3, 4'd3, ST_WAIT);
        rally(12'd100, 12'd190, 1'b0, 4'd4, 4'd3, ST_WAIT);
        rally(12'd100, 12'd190, 1'b0, 4'd5, 4'd3, ST_END);
`else
        rally(12'd100, 12'd250, 1'b0, 4'd3, 4'd1, ST_END);
`endif
        Ball_Y = 12'd190;
        repeat (3) step();
        Ball_Y = 12'd0;
        press(1'b0, 4'd0, 4'd0);

        Ball_X = 12'd200;
        Ball_Y = 12'd190;
        expect_ev(ST_WAIT, 1'b1, 4'd0, 4'd1, 1'b1, cyc + 1);
        step();
        Ball_Y = 12'd0;
        step();
        step();
        reset_n = 1'b0;
        #2;
        chk_reset_vals("async_rst");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        press(1'b0, 4'd0, 4'd0);
        rally(12'd300, 12'd200, 1'b1, 4'd0, 4'd1, ST_WAIT);

        repeat (2) step();
        chk("queue_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
